gate_tester: RTL and testbench

GATE_TESTER -- requirements
Module: gate_tester

---
 rtl/gate_tester.sv | 133 +++++++++++++
 tb/tb_gate_tester.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_tester.sv
// Exhaustive two-input gate tester.
// Drives the four input vectors (0,0), (0,1), (1,0), (1,1) onto a/b in that order.
// After each vector it waits SETTLE cycles, then compares the response y with the
// truth table selected by func. It reports per-vector mismatches and a pass flag.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin a test sequence (sampled only while idle)
//   func     - expected function, latched on start:
//              0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(a), 7 NOT(a)
//   a, b     - stimulus to the gate under test (a = idx[1], b = idx[0])
//   y        - response from the gate under test
//   busy     - high whenever a sequence is running
//   done     - one-cycle pulse when a sequence completes
//   pass     - last sequence had zero mismatches
//   err_cnt  - mismatch count of the last sequence (0..4)
//   fail_vec - bit i set when vector i mismatched
module gate_tester #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StWait,
    StCheck,
    StDone
  } state_e;

  localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

  state_e     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic [2:0] func_q;
  logic       pass_q;
  logic [2:0] err_cnt_q;
  logic [3:0] fail_vec_q;

  function automatic logic expected_y(input logic [2:0] f, input logic ai, input logic bi);
    logic r;
    case (f)
      3'd0:    r = ai & bi;
      3'd1:    r = ai | bi;
      3'd2:    r = ~(ai & bi);
      3'd3:    r = ~(ai | bi);
      3'd4:    r = ai ^ bi;
      3'd5:    r = ~(ai ^ bi);
      3'd6:    r = ai;
      default: r = ~ai;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      func_q     <= 3'd0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 3'd0;
      fail_vec_q <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            func_q     <= func;
            idx_q      <= 2'd0;
            err_cnt_q  <= 3'd0;
            fail_vec_q <= 4'd0;
            pass_q     <= 1'b0;
            state_q    <= StApply;
          end
        end
        StApply: begin
          cnt_q   <= SettleInit;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StCheck: begin
          // At most four checks per sequence, so err_cnt cannot pass 4.
          if (y != expected_y(func_q, idx_q[1], idx_q[0])) begin
            err_cnt_q         <= err_cnt_q + 3'd1;
            fail_vec_q[idx_q] <= 1'b1;
          end
          if (idx_q == 2'd3) begin
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= StApply;
          end
        end
        StDone: begin
          // err_cnt already includes the final CHECK update here.
          pass_q  <= (err_cnt_q == 3'd0);
          idx_q   <= 2'd0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a        = idx_q[1];
  assign b        = idx_q[0];
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (SETTLE=2 and SETTLE=1). Each one feeds a
// gate under test that is modelled as a 4-bit truth table. Expected results come
// from the XOR of the expected and actual truth tables.
module tb_gate_tester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start2, start1;
  logic [2:0] func2, func1;
  logic [3:0] tt2, tt1;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [2:0] err2, err1;
  logic [3:0] fv2, fv1;

  int checks = 0;
  int failures = 0;

  // Selects which instance the tasks drive and observe: 0 -> SETTLE=2, 1 -> SETTLE=1.
  logic       sel;
  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [2:0] m_err;
  logic [3:0] m_fv;

  always #5 clk = ~clk;

  // Gate under test: bit {a,b} of the truth table.
  assign y2 = tt2[{a2, b2}];
  assign y1 = tt1[{a1, b1}];

  gate_tester #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .func(func2), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2)
  );

  gate_tester #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .func(func1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
  );

  always_comb begin
    if (sel) begin
      m_a = a1; m_b = b1; m_busy = busy1; m_done = done1;
      m_pass = pass1; m_err = err1; m_fv = fv1;
    end else begin
      m_a = a2; m_b = b2; m_busy = busy2; m_done = done2;
      m_pass = pass2; m_err = err2; m_fv = fv2;
    end
  end

  // Truth table of each function; bit i is the output for vector i = {a,b}.
  function automatic logic [3:0] truth(input logic [2:0] f);
    case (f)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v; else start2 = v;
  endtask

  task automatic set_func(input logic [2:0] f);
    if (sel) func1 = f; else func2 = f;
  endtask

  // Runs one sequence. Cycle n = 1 is the first cycle after the accepting edge.
  task automatic run_seq(input string tag, input logic [2:0] f, input logic [3:0] gate,
                         input bit repulse, input bit hold);
    int s, lat, vi, done_at, done_n;
    bit ab_bad, busy_bad, eb, got;
    logic [3:0] exp_fv, fv_s;
    logic [2:0] exp_err, err_s;
    logic       exp_pass, pass_s;
    s        = sel ? 1 : 2;
    lat      = 4 * (s + 2) + 1;
    done_at  = 0;
    done_n   = 0;
    ab_bad   = 1'b0;
    busy_bad = 1'b0;
    fv_s     = 4'd0;
    err_s    = 3'd0;
    pass_s   = 1'b0;
    exp_fv   = truth(f) ^ gate;
    exp_err  = 3'($countones(exp_fv));
    exp_pass = (exp_fv == 4'd0);
    if (sel) tt1 = gate; else tt2 = gate;
    @(negedge clk);
    set_start(1'b1);
    set_func(f);
    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clk);
      if (m_done) begin
        done_n++;
        if (done_at == 0) done_at = n;
      end
      vi = (n <= lat) ? (n - 1) / (s + 2) : 0;
      if (vi > 3) vi = 3;
      if ({m_a, m_b} !== 2'(vi)) ab_bad = 1'b1;
      if (n <= lat) eb = 1'b1;
      else if (hold) eb = (n >= lat + 2);
      else eb = 1'b0;
      if (m_busy !== eb) busy_bad = 1'b1;
      if (n == lat + 1) begin
        pass_s = m_pass;
        err_s  = m_err;
        fv_s   = m_fv;
      end
      // Later func changes must not affect the running sequence.
      set_func(3'($urandom_range(7)));
      if (n == 1 && !hold) set_start(1'b0);
      if (repulse && n == s + 4) set_start(1'b1);
      if (repulse && n == s + 5) set_start(1'b0);
    end
    check({tag, ".done_cycle"}, 16'(done_at), 16'(lat));
    check({tag, ".done_pulses"}, 16'(done_n), 16'd1);
    check({tag, ".ab_order"}, 16'(ab_bad), 16'd0);
    check({tag, ".busy"}, 16'(busy_bad), 16'd0);
    check({tag, ".err_cnt"}, 16'(err_s), 16'(exp_err));
    check({tag, ".fail_vec"}, 16'(fv_s), 16'(exp_fv));
    check({tag, ".pass"}, 16'(pass_s), 16'(exp_pass));
    if (hold) begin
      set_start(1'b0);
      got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
        @(negedge clk);
        if (m_done) got = 1'b1;
      end
      check({tag, ".second_done"}, 16'(got), 16'd1);
      @(negedge clk);
    end else begin
      // Results must hold while idle.
      @(negedge clk);
      check({tag, ".hold"}, {5'd0, m_pass, m_err, m_fv, 3'd0},
            {5'd0, exp_pass, exp_err, exp_fv, 3'd0});
    end
  endtask

  initial begin
    bit ok_nd;
    rst_n  = 1'b0;
    start2 = 1'b0;
    start1 = 1'b0;
    func2  = 3'd0;
    func1  = 3'd0;
    tt2    = 4'd0;
    tt1    = 4'd0;
    sel    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.dut2", {4'd0, busy2, done2, pass2, a2, b2, err2, fv2}, 16'd0);
    check("reset.dut1", {4'd0, busy1, done1, pass1, a1, b1, err1, fv1}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    sel = 1'b0;
    run_seq("nand_ok", 3'd2, truth(3'd2), 1'b0, 1'b0);
    run_seq("nand_stuck1", 3'd2, 4'b1111, 1'b0, 1'b0);
    run_seq("and_vs_nand", 3'd0, truth(3'd2), 1'b0, 1'b0);
    run_seq("repulse", 3'd2, truth(3'd2), 1'b1, 1'b0);

    // Reset during WAIT of vector 2 (cycle 10 with SETTLE=2).
    tt2 = truth(3'd2);
    @(negedge clk);
    start2 = 1'b1;
    func2  = 3'd2;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start2 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midreset.state", {5'd0, busy2, done2, pass2, a2, b2, err2, fv2, 1'b0}, 16'd0);
    ok_nd = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done2 !== 1'b0 || busy2 !== 1'b0) ok_nd = 1'b0;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done2 !== 1'b0) ok_nd = 1'b0;
    end
    check("midreset.no_done", 16'(ok_nd), 16'd1);
    run_seq("after_reset", 3'd2, truth(3'd2), 1'b0, 1'b0);

    sel = 1'b1;
    run_seq("xor_settle1", 3'd4, truth(3'd4), 1'b0, 1'b0);

    sel = 1'b0;
    run_seq("start_held", 3'd1, truth(3'd1), 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom_range(1));
      run_seq("random", 3'($urandom_range(7)), 4'($urandom_range(15)), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
